// File: rtl/tcp_vlg_tx_sched.sv
// tcp_vlg_tx_sched
//   Arbitrates the TCP transmit engine between buffered payload segments,
//   pure ACKs and a single FIN. Holds one payload descriptor, delays ACKs so
//   they can ride on a payload segment, and caps consecutive pure ACKs while
//   a payload waits. Drives a req/ack/done handshake towards the TX module.
//
//   Handshake with the TX module: o_tx_req rises with all o_tx_* fields
//   valid and stays high, fields frozen, until the cycle i_tx_ack is
//   sampled high (the TX module latches the fields in that same cycle).
//   The segment is then in flight until i_tx_done; i_tx_done may coincide
//   with i_tx_ack. An outstanding request is never withdrawn except by rst.
module tcp_vlg_tx_sched #(
  parameter int ACK_DELAY_TICKS = 1000,
  parameter int MAX_ACK_BURST   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pld_pend,
  input  logic [31:0] i_pld_start,
  input  logic [15:0] i_pld_lng,
  input  logic [31:0] i_pld_cks,
  input  logic        i_ack_req,
  input  logic        i_fin_req,
  input  logic        i_flush,
  input  logic [31:0] i_loc_seq,
  input  logic [31:0] i_rem_seq,
  input  logic        i_tx_ack,
  input  logic        i_tx_done,
  output logic        o_tx_req,
  output logic [1:0]  o_tx_kind,
  output logic [31:0] o_tx_seq,
  output logic [31:0] o_tx_ackn,
  output logic [15:0] o_tx_lng,
  output logic [31:0] o_tx_cks,
  output logic        o_tx_idle,
  output logic        o_fin_sent,
  output logic        o_ovf,
  output logic [1:0]  o_dbg_state
);

  localparam int DW = $clog2(ACK_DELAY_TICKS + 1);
  localparam int BW = $clog2(MAX_ACK_BURST + 1);
  localparam logic [DW-1:0] DLY_MAX   = DW'(ACK_DELAY_TICKS);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_ACK_BURST);

  localparam logic [1:0] KIND_ACK = 2'd0;
  localparam logic [1:0] KIND_PLD = 2'd1;
  localparam logic [1:0] KIND_FIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    REQ_S  = 2'd1,
    BUSY_S = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Payload buffer
  logic        r_pbuf_vld;
  logic [31:0] r_pbuf_start;
  logic [15:0] r_pbuf_lng;
  logic [31:0] r_pbuf_cks;
  logic        r_ovf;

  // Delayed ACK and anti-starvation state
  logic          r_ack_pend;
  logic [DW-1:0] r_dly_ctr;
  logic [BW-1:0] r_burst_ctr;
  logic          r_fin_sent;

  // Registered segment fields
  logic [1:0]  r_tx_kind;
  logic [31:0] r_tx_seq;
  logic [31:0] r_tx_ackn;
  logic [15:0] r_tx_lng;
  logic [31:0] r_tx_cks;

  // Selection and accept qualifiers
  logic w_dly_sat;
  logic w_burst_sat;
  logic w_fin_want;
  logic w_sel_ack;
  logic w_sel_pld;
  logic w_sel_fin;
  logic w_in_idle;
  logic w_go_ack;
  logic w_go_pld;
  logic w_go_fin;
  logic w_select;
  logic w_accept;
  logic w_acc_eff;
  logic w_acc_ack;
  logic w_acc_pld;
  logic w_acc_fin;

  assign w_dly_sat   = (r_dly_ctr == DLY_MAX);
  assign w_burst_sat = (r_burst_ctr == BURST_MAX);
  assign w_fin_want  = i_fin_req && !r_fin_sent;

  // ACK goes alone once it has waited long enough, or when it must precede a
  // FIN; it is held back while a payload has been starved by a full burst.
  // Nothing that flush is about to discard is selected.
  assign w_sel_ack = !i_flush && r_ack_pend
                     && (w_dly_sat || (!r_pbuf_vld && w_fin_want))
                     && !(r_pbuf_vld && w_burst_sat);
  assign w_sel_pld = !i_flush && !w_sel_ack && r_pbuf_vld;
  assign w_sel_fin = !w_sel_ack && !w_sel_pld && w_fin_want
                     && !r_pbuf_vld && !r_ack_pend;

  assign w_in_idle = (r_state == IDLE_S);
  assign w_go_ack  = w_in_idle && w_sel_ack;
  assign w_go_pld  = w_in_idle && w_sel_pld;
  assign w_go_fin  = w_in_idle && w_sel_fin;
  assign w_select  = w_go_ack || w_go_pld || w_go_fin;

  // Accept-side bookkeeping is suppressed while flush is high.
  assign w_accept  = (r_state == REQ_S) && i_tx_ack;
  assign w_acc_eff = w_accept && !i_flush;
  assign w_acc_ack = w_acc_eff && (r_tx_kind == KIND_ACK);
  assign w_acc_pld = w_acc_eff && (r_tx_kind == KIND_PLD);
  assign w_acc_fin = w_acc_eff && (r_tx_kind == KIND_FIN);

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE_S;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE_S: if (w_select) w_state_nxt = REQ_S;
      REQ_S: begin
        if (i_tx_ack) w_state_nxt = i_tx_done ? IDLE_S : BUSY_S;
      end
      BUSY_S: if (i_tx_done) w_state_nxt = IDLE_S;
      default: w_state_nxt = IDLE_S;
    endcase
  end

  // FSM outputs: request level, idle indication and debug state
  always_comb begin
    o_tx_req    = (r_state == REQ_S);
    o_tx_idle   = (r_state == IDLE_S) && !r_pbuf_vld;
    o_dbg_state = r_state;
  end

  // Segment fields are captured at selection and frozen until the next one
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_kind <= KIND_ACK;
      r_tx_seq  <= '0;
      r_tx_ackn <= '0;
      r_tx_lng  <= '0;
      r_tx_cks  <= '0;
    end else if (w_select) begin
      r_tx_ackn <= i_rem_seq;
      if (w_go_pld) begin
        r_tx_kind <= KIND_PLD;
        r_tx_seq  <= r_pbuf_start;
        r_tx_lng  <= r_pbuf_lng;
        r_tx_cks  <= r_pbuf_cks;
      end else begin
        r_tx_kind <= w_go_fin ? KIND_FIN : KIND_ACK;
        r_tx_seq  <= i_loc_seq;
        r_tx_lng  <= '0;
        r_tx_cks  <= '0;
      end
    end
  end

  // Single-entry payload buffer with sticky overflow flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pbuf_vld   <= 1'b0;
      r_pbuf_start <= '0;
      r_pbuf_lng   <= '0;
      r_pbuf_cks   <= '0;
      r_ovf        <= 1'b0;
    end else if (i_flush) begin
      r_pbuf_vld <= 1'b0;
    end else begin
      if (w_acc_pld) r_pbuf_vld <= 1'b0;
      if (i_pld_pend) begin
        if (!r_pbuf_vld) begin
          r_pbuf_vld   <= 1'b1;
          r_pbuf_start <= i_pld_start;
          r_pbuf_lng   <= i_pld_lng;
          r_pbuf_cks   <= i_pld_cks;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // Pending ACK and its saturating delay counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack_pend <= 1'b0;
      r_dly_ctr  <= '0;
    end else if (i_flush) begin
      r_ack_pend <= 1'b0;
      r_dly_ctr  <= '0;
    end else begin
      if (w_go_pld || w_acc_ack) begin
        r_ack_pend <= 1'b0;
        r_dly_ctr  <= '0;
      end else if (r_ack_pend && !w_dly_sat) begin
        r_dly_ctr <= r_dly_ctr + 1'b1;
      end
      // A fresh request only restarts the timer when no ACK is still owed
      if (i_ack_req && (!r_ack_pend || w_go_pld || w_acc_ack)) begin
        r_ack_pend <= 1'b1;
        r_dly_ctr  <= '0;
      end
    end
  end

  // Consecutive pure ACKs sent while a payload waits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_burst_ctr <= '0;
    end else if (i_flush || w_acc_pld) begin
      r_burst_ctr <= '0;
    end else if (w_acc_ack && r_pbuf_vld && !w_burst_sat) begin
      r_burst_ctr <= r_burst_ctr + 1'b1;
    end
  end

  // Sticky FIN-sent flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_fin_sent <= 1'b0;
    else if (w_acc_fin) r_fin_sent <= 1'b1;
  end

  assign o_tx_kind  = r_tx_kind;
  assign o_tx_seq   = r_tx_seq;
  assign o_tx_ackn  = r_tx_ackn;
  assign o_tx_lng   = r_tx_lng;
  assign o_tx_cks   = r_tx_cks;
  assign o_fin_sent = r_fin_sent;
  assign o_ovf      = r_ovf;

endmodule
